// File: rtl/dc_pkg.sv
// Definitions shared by the DC frame dispatcher and the DAC update sequencer.
package dc_pkg;

  localparam int unsigned DAC_CHANNEL  = 24;
  localparam int unsigned FRAME_WORDS  = 62;
  localparam int unsigned LAUNCH_WORDS = 4;
  localparam logic [31:0] LAUNCH_HDR   = 32'hFFFF_FFFF;

  // Launch command fields: word 0 carries the channel mask, word 1 the delay.
  localparam int unsigned LAUNCH_MASK_WORD  = 0;
  localparam int unsigned LAUNCH_MASK_LSB   = 0;
  localparam int unsigned LAUNCH_MASK_W     = DAC_CHANNEL;
  localparam int unsigned LAUNCH_DELAY_WORD = 1;
  localparam int unsigned LAUNCH_DELAY_LSB  = 0;
  localparam int unsigned LAUNCH_DELAY_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_LAUNCH_WAIT
  } dc_state_e;

endpackage

// File: rtl/dc_launch_timer.sv
// 16-bit load/count/fire down-counter; o_done pulses D+1 cycles after a load of D.
module dc_launch_timer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [15:0] i_delay,
  output logic        o_expiring,
  output logic        o_done
);

  logic [15:0] cnt;
  logic        active;

  // o_expiring is the combinational look-ahead of o_done, so callers can
  // register data that must line up with the done pulse.
  assign o_expiring = i_load ? (i_delay == '0) : (active && (cnt == 16'd1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt    <= '0;
      active <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= o_expiring;
      if (i_load) begin
        cnt    <= i_delay;
        active <= (i_delay != '0);
      end else if (active) begin
        cnt <= cnt - 16'd1;
        if (cnt == 16'd1) active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dc_update_sequencer.sv
// Streams captured DC frames to the shared DAC serializer and executes
// delayed launch commands, tracking which channels hold fresh values.
module dc_update_sequencer
  import dc_pkg::*;
(
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_frame_valid,
  input  logic [FRAME_WORDS-1:0][31:0]      i_dc_regs,
  input  logic [4:0]                        i_channel_sel,
  input  logic                              i_launch_valid,
  input  logic [LAUNCH_WORDS-1:0][31:0]     i_launch_cmd,
  output logic [31:0]                       o_ser_data,
  output logic [4:0]                        o_ser_chan,
  output logic                              o_ser_valid,
  output logic                              o_ser_last,
  input  logic                              i_ser_ready,
  output logic                              o_launch_trig,
  output logic [DAC_CHANNEL-1:0]            o_launch_mask,
  output logic [DAC_CHANNEL-1:0]            o_loaded_mask,
  output logic                              o_busy,
  output logic                              o_drop
);

  dc_state_e                      state;
  logic [5:0]                     idx;
  logic [FRAME_WORDS-1:1][31:0]   pay_buf;
  logic                           pend_v;
  logic [DAC_CHANNEL-1:0]         pend_mask;
  logic [15:0]                    pend_delay;
  logic [DAC_CHANNEL-1:0]         cmd_mask;

  logic [DAC_CHANNEL-1:0]         new_mask, ld_mask;
  logic [15:0]                    new_delay, ld_delay;
  logic                           hs, last_hs, idle_free, consume, launch_direct;
  logic                           store, drop_launch, drop_frame;
  logic                           tmr_load, tmr_expiring, tmr_done;
  logic                           unused_bits;

  assign unused_bits = ^{i_dc_regs[0], i_launch_cmd[3], i_launch_cmd[2],
                         i_launch_cmd[LAUNCH_MASK_WORD][31:LAUNCH_MASK_W],
                         i_launch_cmd[LAUNCH_DELAY_WORD][31:LAUNCH_DELAY_W]};

  // The pending slot is freed in the same cycle it is consumed, so a launch
  // arriving in that cycle is kept rather than dropped.
  always_comb begin
    new_mask      = i_launch_cmd[LAUNCH_MASK_WORD][LAUNCH_MASK_LSB +: LAUNCH_MASK_W];
    new_delay     = i_launch_cmd[LAUNCH_DELAY_WORD][LAUNCH_DELAY_LSB +: LAUNCH_DELAY_W];
    hs            = o_ser_valid && i_ser_ready;
    last_hs       = hs && o_ser_last;
    idle_free     = (state == ST_IDLE) && !i_frame_valid;
    consume       = pend_v && (idle_free || last_hs);
    launch_direct = idle_free && !pend_v && i_launch_valid;
    tmr_load      = consume || launch_direct;
    ld_mask       = consume ? pend_mask : new_mask;
    ld_delay      = consume ? pend_delay : new_delay;
    store         = i_launch_valid && !launch_direct && (!pend_v || consume);
    drop_launch   = i_launch_valid && !launch_direct && !store;
    drop_frame    = i_frame_valid && (state != ST_IDLE);
  end

  assign o_busy        = (state != ST_IDLE) || pend_v;
  assign o_launch_trig = tmr_done;

  dc_launch_timer u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (tmr_load),
    .i_delay    (ld_delay),
    .o_expiring (tmr_expiring),
    .o_done     (tmr_done)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= ST_IDLE;
      idx           <= '0;
      pay_buf       <= '0;
      o_ser_data    <= '0;
      o_ser_chan    <= '0;
      o_ser_valid   <= 1'b0;
      o_ser_last    <= 1'b0;
      pend_v        <= 1'b0;
      pend_mask     <= '0;
      pend_delay    <= '0;
      cmd_mask      <= '0;
      o_launch_mask <= '0;
      o_loaded_mask <= '0;
      o_drop        <= 1'b0;
    end else begin
      o_drop <= drop_frame || drop_launch;
      if (tmr_expiring) o_launch_mask <= tmr_load ? ld_mask : cmd_mask;
      if (tmr_load) cmd_mask <= ld_mask;
      if (consume) pend_v <= 1'b0;
      if (store) begin
        pend_v     <= 1'b1;
        pend_mask  <= new_mask;
        pend_delay <= new_delay;
      end

      case (state)
        ST_IDLE: begin
          if (i_frame_valid) begin
            pay_buf     <= i_dc_regs[FRAME_WORDS-1:1];
            o_ser_data  <= i_dc_regs[1];
            o_ser_chan  <= i_channel_sel;
            o_ser_valid <= 1'b1;
            o_ser_last  <= 1'b0;
            idx         <= 6'd1;
            state       <= ST_STREAM;
          end else if (tmr_load) begin
            state <= ST_LAUNCH_WAIT;
          end
        end
        ST_STREAM: begin
          if (hs) begin
            if (o_ser_last) begin
              o_ser_valid   <= 1'b0;
              o_ser_last    <= 1'b0;
              // Out-of-range channels shift the bit off the top of the mask.
              o_loaded_mask <= o_loaded_mask | (DAC_CHANNEL'(1) << o_ser_chan);
              state         <= pend_v ? ST_LAUNCH_WAIT : ST_IDLE;
            end else begin
              idx        <= idx + 6'd1;
              o_ser_data <= pay_buf[idx + 6'd1];
              o_ser_last <= ((idx + 6'd1) == 6'(FRAME_WORDS - 1));
            end
          end
        end
        ST_LAUNCH_WAIT: begin
          if (tmr_done) begin
            o_loaded_mask <= o_loaded_mask & ~cmd_mask;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dc_update_sequencer.md
# dc_update_sequencer

Sequences DC-frame and launch traffic produced by the DC frame dispatcher toward the single shared DAC serializer. It captures each completed 62-word frame, streams its 61 payload words to the serializer over a valid/ready handshake tagged with the target channel, and tracks which channels hold a freshly loaded value. It also executes launch commands, with a programmable delay, as a single trigger pulse. It sits between the dispatcher outputs and the DAC serializer/LDAC logic.

## Interface
- DAC_CHANNEL, 24, number of DAC channels (mask width)
- FRAME_WORDS, 62, words per DC frame (word 0 = header, 1..61 = payload)
- i_clk  in  1  sole clock, all logic on rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_frame_valid  in  1  one-cycle pulse: i_dc_regs/i_channel_sel valid
- i_dc_regs  in  FRAME_WORDS×32  frame words, packed [FRAME_WORDS-1:0][31:0]
- i_channel_sel  in  5  target channel of frame (0..DAC_CHANNEL-1)
- i_launch_valid  in  1  one-cycle pulse: i_launch_cmd valid
- i_launch_cmd  in  4×32  word0[23:0] = channel mask, word1[15:0] = delay cycles, words 2–3 reserved/ignored
- o_ser_data  out  32  payload word to serializer
- o_ser_chan  out  5  channel tag of o_ser_data
- o_ser_valid  out  1  beat valid
- o_ser_last  out  1  high with the final beat (word 61)
- i_ser_ready  in  1  serializer accepts beat when valid&&ready
- o_launch_trig  out  1  one-cycle launch strobe
- o_launch_mask  out  24  mask qualifying o_launch_trig, held until the next launch
- o_loaded_mask  out  24  channels streamed since their last launch
- o_busy  out  1  state != IDLE or a launch is pending
- o_drop  out  1  one-cycle pulse: incoming frame or launch discarded

## Operation
- States: IDLE, STREAM, LAUNCH_WAIT.
- IDLE + i_frame_valid: capture i_dc_regs words 1..61 and i_channel_sel into the internal buffer; word index := 1; → STREAM.
- IDLE + i_launch_valid (no frame): capture mask and delay; → LAUNCH_WAIT.
- IDLE with both pulses in the same cycle: frame is taken first; launch is stored in the one-deep pending slot.
- STREAM: o_ser_valid=1, o_ser_data=buf[index], o_ser_chan=captured channel. Index increments on each handshake. o_ser_last=1 when index==61.
  - On the last handshake, set o_loaded_mask[chan]. Then → LAUNCH_WAIT if a launch is pending, else → IDLE.
- LAUNCH_WAIT: a 16-bit down-counter is loaded with the delay. When it reaches 0:
  - o_launch_trig=1 for one cycle; o_launch_mask := cmd mask.
  - o_loaded_mask &= ~cmd mask.
  - → IDLE.
- Frame pulse outside IDLE: discarded, o_drop pulse; the buffer is unchanged.
- Launch pulse outside IDLE: stored if the pending slot is empty, else discarded with an o_drop pulse.
- Launch with mask 0: still fires the trigger; o_loaded_mask is unchanged.
- Channel select ≥ DAC_CHANNEL: the frame is streamed but o_loaded_mask is not updated.

## Timing
- Reset values: all outputs 0; state IDLE; pending slot empty; buffer 0.
- Frame pulse at cycle t (IDLE) → o_ser_valid rises at t+1 carrying word 1.
- With i_ser_ready held high: 61 beats on cycles t+1..t+61; o_ser_last at t+61; IDLE at t+62.
- With ready low: o_ser_data/chan/last stay stable while valid is high; valid never drops mid-frame.
- Launch in IDLE at t with delay D → o_launch_trig at t+1+D; IDLE at t+2+D.
- Pending launch: LAUNCH_WAIT is entered the cycle after the last handshake, with the same D+1 latency.
- o_drop is registered: it asserts the cycle after the discarded pulse.
- Reset mid-STREAM or mid-wait: the operation is abandoned; no trigger and no loaded-mask update.

## Structure
- Shared package dc_pkg holds: the state enum, DAC_CHANNEL, FRAME_WORDS, LAUNCH_WORDS=4, LAUNCH_HDR=32'hFFFF_FFFF, and launch-field bit positions. The dispatcher uses the same package.
- Sub-module dc_launch_timer: load/count/fire down-counter, 16-bit, producing a done pulse.
- Payload buffer: flops (61×32); no RAM.

## Test plan
- Frame, channel 5, word k = 32'hA000_0000+k, ready=1 → 61 beats on consecutive cycles carrying A000_0001..A000_003D, chan=5, last only on 003D; loaded_mask=0x000020.
- Same frame with ready toggling 1-0 every cycle → identical data order; data stable during stalls; 122-cycle stream.
- Launch mask 0x000020, delay 10, issued in IDLE at t → trig at t+11, launch_mask=0x000020, loaded_mask→0.
- Frame and launch (mask 0xFFFFFF, delay 0) in the same cycle → full stream first; trig the cycle after the last handshake +1; loaded_mask ends at 0.
- Second frame pulse during STREAM, then two launches during STREAM → one o_drop for the frame and one for the second launch; only the first launch fires.
- Reset asserted at beat 30 → all outputs 0 immediately; after release a new frame streams from word 1.
